// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO with valid/ready toward decode
// and single-cycle flush. Define INST_Q_BYPASS_EN for fall-through (zero-latency) mode.

module inst_queue_entry #(
    parameter int W = 97
) (
    input  logic         CLK,
    input  logic         we_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o
);
    logic [W-1:0] data_q;

    // Payload storage is deliberately not reset; validity comes from the pointers.
    always_ff @(posedge CLK) begin
        if (we_i) data_q <= wdata_i;
    end

    assign rdata_o = data_q;
endmodule

module inst_queue #(
    parameter int INST_Q_WIDTH = 97,
    parameter int INST_Q_DEPTH = 4,
    parameter int INST_Q_PTR   = 2
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    inst_q_wen,
    input  logic [INST_Q_WIDTH-1:0] inst_q_wdata,
    output logic                    inst_q_wok,
    input  logic                    q_flush,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [INST_Q_WIDTH-1:0] dec_data,
    output logic [INST_Q_PTR:0]     q_count,
    output logic                    q_ovf
);
    localparam int PW = INST_Q_PTR + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;

    logic [INST_Q_DEPTH-1:0][INST_Q_WIDTH-1:0] mem;
    logic [INST_Q_DEPTH-1:0]                   ent_we;
    logic [INST_Q_WIDTH-1:0]                   head_data;

    logic empty, full;
    logic head_valid, wfire, rfire, store, byp_take;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[INST_Q_PTR-1:0] == rd_ptr_q[INST_Q_PTR-1:0]) &&
                   (wr_ptr_q[INST_Q_PTR] != rd_ptr_q[INST_Q_PTR]);

    // Fetch back-pressure sees only registered state, never dec_ready.
    assign inst_q_wok = ~full;
    assign wfire      = inst_q_wen & inst_q_wok & ~q_flush;
    assign head_valid = ~empty & ~q_flush;
    assign rfire      = head_valid & dec_ready;
    assign head_data  = mem[rd_ptr_q[INST_Q_PTR-1:0]];

`ifdef INST_Q_BYPASS_EN
    logic byp;
    // Empty queue with a write pending: hand the write straight to decode.
    assign byp       = empty & inst_q_wen & ~q_flush;
    assign byp_take  = byp & dec_ready;
    assign dec_valid = head_valid | byp;
    assign dec_data  = !dec_valid ? '0 : (byp ? inst_q_wdata : head_data);
`else
    assign byp_take  = 1'b0;
    assign dec_valid = head_valid;
    assign dec_data  = dec_valid ? head_data : '0;
`endif

    // A bypassed-and-consumed entry never lands in storage.
    assign store = wfire & ~byp_take;

    generate
        for (genvar i = 0; i < INST_Q_DEPTH; i++) begin : g_ent
            assign ent_we[i] = store && (wr_ptr_q[INST_Q_PTR-1:0] == INST_Q_PTR'(i));
            inst_queue_entry #(.W(INST_Q_WIDTH)) u_ent (
                .CLK     (CLK),
                .we_i    (ent_we[i]),
                .wdata_i (inst_q_wdata),
                .rdata_o (mem[i])
            );
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (inst_q_wen & ~inst_q_wok & ~q_flush);
        if (q_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rfire) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q_count = wr_ptr_q - rd_ptr_q;
    assign q_ovf   = ovf_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/drain, streaming, flush, bypass, overflow.
`timescale 1ns/1ps

module tb_inst_queue;
    localparam int W = 97;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         inst_q_wen;
    logic [W-1:0] inst_q_wdata;
    logic         inst_q_wok;
    logic         q_flush;
    logic         dec_valid;
    logic         dec_ready;
    logic [W-1:0] dec_data;
    logic [2:0]   q_count;
    logic         q_ovf;

    int total = 0;
    int bad   = 0;

    inst_queue #(.INST_Q_WIDTH(97), .INST_Q_DEPTH(4), .INST_Q_PTR(2)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .inst_q_wen   (inst_q_wen),
        .inst_q_wdata (inst_q_wdata),
        .inst_q_wok   (inst_q_wok),
        .q_flush      (q_flush),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .q_count      (q_count),
        .q_ovf        (q_ovf)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] mk(input logic [31:0] inst);
        return {inst[0], inst + 32'h1000_0004, inst + 32'h1000_0000, inst};
    endfunction

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; inst_q_wen = 1'b0; inst_q_wdata = '0; q_flush = 1'b0; dec_ready = 1'b0;
        tick(); tick();
        RSTN = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", dec_valid); end
        total++; if (dec_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", dec_data); end
        total++; if (q_count !== 3'd0 || inst_q_wok !== 1'b1 || q_ovf !== 1'b0) begin
            bad++; $display("FAIL rst_state cnt=%0d wok=%b ovf=%b exp 0/1/0", q_count, inst_q_wok, q_ovf);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            inst_q_wen = 1'b1; inst_q_wdata = mk(32'h50 + i);
            tick();
        end
        inst_q_wen = 1'b0;
        #1;
        total++; if (q_count !== 3'd3) begin bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", q_count); end
        #2 RSTN = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0 || q_count !== 3'd0 || inst_q_wok !== 1'b1 || q_ovf !== 1'b0) begin
            bad++; $display("FAIL async_rst vld=%b cnt=%0d wok=%b ovf=%b exp 0/0/1/0", dec_valid, q_count, inst_q_wok, q_ovf);
        end
        tick();
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_inst [4];
        exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_q_wen = 1'b1; inst_q_wdata = mk(exp_inst[i]);
            tick();
        end
        inst_q_wen = 1'b0;
        #1;
        total++; if (inst_q_wok !== 1'b0 || q_count !== 3'd4) begin
            bad++; $display("FAIL fill_full wok=%b cnt=%0d exp 0/4", inst_q_wok, q_count);
        end
        tick();
        total++; if (dec_valid !== 1'b1 || dec_data !== mk(32'h11)) begin
            bad++; $display("FAIL hold_stable vld=%b data=%h exp 1/%h", dec_valid, dec_data, mk(32'h11));
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (dec_valid !== 1'b1 || dec_data !== mk(exp_inst[i])) begin
                bad++; $display("FAIL drain_%0d vld=%b data=%h exp 1/%h", i, dec_valid, dec_data, mk(exp_inst[i]));
            end
            tick();
            if (i == 0) begin
                total++; if (inst_q_wok !== 1'b1 || q_count !== 3'd3) begin
                    bad++; $display("FAIL wok_rise wok=%b cnt=%0d exp 1/3", inst_q_wok, q_count);
                end
            end
        end
        dec_ready = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0 || q_count !== 3'd0) begin
            bad++; $display("FAIL drained vld=%b cnt=%0d exp 0/0", dec_valid, q_count);
        end
    endtask

    task automatic test_stream();
        int errs = 0;
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            inst_q_wen = 1'b1; inst_q_wdata = mk(32'h100 + i);
            #1;
            if (q_count > 3'd1) errs++;
`ifdef INST_Q_BYPASS_EN
            if (dec_valid !== 1'b1 || dec_data !== mk(32'h100 + i)) errs++;
`else
            if (i > 0 && (dec_valid !== 1'b1 || dec_data !== mk(32'h100 + i - 1))) errs++;
`endif
            tick();
        end
        inst_q_wen = 1'b0;
        #1;
        total++; if (errs != 0) begin bad++; $display("FAIL stream_order errors=%0d exp=0", errs); end
`ifndef INST_Q_BYPASS_EN
        total++; if (dec_valid !== 1'b1 || dec_data !== mk(32'h113)) begin
            bad++; $display("FAIL stream_last vld=%b data=%h exp 1/%h", dec_valid, dec_data, mk(32'h113));
        end
`endif
        tick();
        dec_ready = 1'b0;
        #1;
        total++; if (q_count !== 3'd0 || q_ovf !== 1'b0) begin
            bad++; $display("FAIL stream_end cnt=%0d ovf=%b exp 0/0", q_count, q_ovf);
        end
    endtask

    task automatic test_flush();
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_q_wen = 1'b1; inst_q_wdata = mk(32'h31 + i);
            tick();
        end
        q_flush = 1'b1; inst_q_wen = 1'b1; inst_q_wdata = mk(32'h77); dec_ready = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0 || dec_data !== '0) begin
            bad++; $display("FAIL flush_cycle vld=%b data=%h exp 0/0", dec_valid, dec_data);
        end
        tick();
        q_flush = 1'b0; inst_q_wen = 1'b0; dec_ready = 1'b0;
        #1;
        total++; if (q_count !== 3'd0 || dec_valid !== 1'b0 || q_ovf !== 1'b0) begin
            bad++; $display("FAIL flush_after cnt=%0d vld=%b ovf=%b exp 0/0/0", q_count, dec_valid, q_ovf);
        end
        tick();
        inst_q_wen = 1'b1; inst_q_wdata = mk(32'h55);
        tick();
        inst_q_wen = 1'b0;
        #1;
        total++; if (q_count !== 3'd1 || dec_data !== mk(32'h55)) begin
            bad++; $display("FAIL flush_reuse cnt=%0d data=%h exp 1/%h", q_count, dec_data, mk(32'h55));
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic test_bypass();
        dec_ready = 1'b1; inst_q_wen = 1'b1; inst_q_wdata = mk(32'hABCD);
        #1;
`ifdef INST_Q_BYPASS_EN
        total++; if (dec_valid !== 1'b1 || dec_data !== mk(32'hABCD)) begin
            bad++; $display("FAIL byp_same vld=%b data=%h exp 1/%h", dec_valid, dec_data, mk(32'hABCD));
        end
        tick();
        inst_q_wen = 1'b0;
        #1;
        total++; if (q_count !== 3'd0 || dec_valid !== 1'b0) begin
            bad++; $display("FAIL byp_after cnt=%0d vld=%b exp 0/0", q_count, dec_valid);
        end
`else
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL nobyp_same vld=%b exp=0", dec_valid); end
        tick();
        inst_q_wen = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b1 || dec_data !== mk(32'hABCD) || q_count !== 3'd1) begin
            bad++; $display("FAIL nobyp_next vld=%b data=%h cnt=%0d exp 1/%h/1", dec_valid, dec_data, q_count, mk(32'hABCD));
        end
        tick();
`endif
        dec_ready = 1'b0;
        #1;
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL byp_empty cnt=%0d exp=0", q_count); end
    endtask

    task automatic test_overflow();
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_q_wen = 1'b1; inst_q_wdata = mk(32'h61 + i);
            tick();
        end
        inst_q_wdata = mk(32'h99);
        #1;
        total++; if (inst_q_wok !== 1'b0 || q_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_pre wok=%b ovf=%b exp 0/0", inst_q_wok, q_ovf);
        end
        tick();
        inst_q_wen = 1'b0;
        #1;
        total++; if (q_ovf !== 1'b1 || q_count !== 3'd4) begin
            bad++; $display("FAIL ovf_set ovf=%b cnt=%0d exp 1/4", q_ovf, q_count);
        end
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (dec_valid !== 1'b1 || dec_data !== mk(32'h61 + i)) begin
                bad++; $display("FAIL ovf_drain_%0d vld=%b data=%h exp 1/%h", i, dec_valid, dec_data, mk(32'h61 + i));
            end
            tick();
        end
        dec_ready = 1'b0;
        #1;
        total++; if (q_ovf !== 1'b1 || dec_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_sticky ovf=%b vld=%b exp 1/0", q_ovf, dec_valid);
        end
        RSTN = 1'b0;
        #1;
        total++; if (q_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear ovf=%b exp=0", q_ovf); end
        tick();
        RSTN = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_bypass();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule
